ecc_scrubber: RTL



---
 rtl/ecc_pkg.sv | 26 ++
 rtl/ecc_err_log.sv | 74 +++++++
 rtl/ecc_scrubber.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ecc_pkg.sv
// Shared ECC definitions: Hamming check-bit sizing,
// scrubber FSM states and counter width.
package ecc_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        NEXT
    } scrub_state_t;

    // Smallest m with 2**m >= k + m + 1.
    function automatic int calc_m(input int k);
        int m;
        m = 0;
        for (int i = 31; i >= 1; i--) begin
            if ((1 << i) >= k + i + 1) m = i;
        end
        return m;
    endfunction

endpackage

// File: rtl/ecc_err_log.sv
// Saturating sb/db error counters plus optional last-error log.
// Log registers exist only when ECC_SCRUBBER_LOG_EN is defined.
module ecc_err_log
    import ecc_pkg::*;
#(
    parameter int AW = 10,
    parameter int SW = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             sb_inc_i,
    input  logic             db_inc_i,
    input  logic             log_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [SW-1:0]    syn_i,
    output logic [CNT_W-1:0] sb_cnt_o,
    output logic [CNT_W-1:0] db_cnt_o,
    output logic [AW-1:0]    err_addr_o,
    output logic [SW-1:0]    err_syndrome_o,
    output logic             err_valid_o
);

    logic [CNT_W-1:0] r_sb_cnt;
    logic [CNT_W-1:0] r_db_cnt;

    // A clear in the same cycle as an event discards the event.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sb_cnt <= '0;
            r_db_cnt <= '0;
        end else if (clr_i) begin
            r_sb_cnt <= '0;
            r_db_cnt <= '0;
        end else begin
            if (sb_inc_i && r_sb_cnt != '1) r_sb_cnt <= r_sb_cnt + 1'b1;
            if (db_inc_i && r_db_cnt != '1) r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    assign sb_cnt_o = r_sb_cnt;
    assign db_cnt_o = r_db_cnt;

`ifdef ECC_SCRUBBER_LOG_EN
    logic [AW-1:0] r_addr;
    logic [SW-1:0] r_syn;
    logic          r_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr  <= '0;
            r_syn   <= '0;
            r_valid <= 1'b0;
        end else if (clr_i) begin
            r_valid <= 1'b0;
        end else if (log_i) begin
            r_addr  <= addr_i;
            r_syn   <= syn_i;
            r_valid <= 1'b1;
        end
    end

    assign err_addr_o     = r_addr;
    assign err_syndrome_o = r_syn;
    assign err_valid_o    = r_valid;
`else
    logic w_unused;
    assign w_unused       = ^{log_i, addr_i, syn_i};
    assign err_addr_o     = '0;
    assign err_syndrome_o = '0;
    assign err_valid_o    = 1'b0;
`endif

endmodule

// File: rtl/ecc_scrubber.sv
// Background ECC scrubber: walks memory, writes back corrected words.
// Optional error log enabled with ECC_SCRUBBER_LOG_EN.
module ecc_scrubber
    import ecc_pkg::*;
#(
    parameter  int K  = 8,
    parameter  int AW = 10,
    localparam int M  = calc_m(K)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic [15:0]      interval_i,
    input  logic             clr_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [AW-1:0]    mem_addr_o,
    output logic [K-1:0]     mem_wdata_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [K-1:0]     dec_q_i,
    input  logic             dec_sb_err_i,
    input  logic             dec_db_err_i,
    input  logic [M:0]       dec_syndrome_i,
    input  logic             fn_wr_i,
    input  logic [AW-1:0]    fn_addr_i,
    output logic [CNT_W-1:0] sb_cnt_o,
    output logic [CNT_W-1:0] db_cnt_o,
    output logic [AW-1:0]    err_addr_o,
    output logic [M:0]       err_syndrome_o,
    output logic             err_valid_o,
    output logic             db_irq_o,
    output logic             pass_done_o,
    output logic             busy_o
);

    scrub_state_t r_state;
    scrub_state_t w_next;

    logic [AW-1:0] r_addr;
    logic [15:0]   r_cnt;
    logic          r_req;
    logic          r_we;
    logic [K-1:0]  r_wdata;
    logic          r_hz;
    logic          r_irq;
    logic          r_pass;

    logic w_hit;
    logic w_rd_ev;
    logic w_db;
    logic w_sb;
    logic w_cancel;
    logic w_sb_inc;

    assign w_hit    = fn_wr_i && (fn_addr_i == r_addr);
    assign w_rd_ev  = (r_state == RD_WAIT) && mem_rvalid_i;
    assign w_db     = w_rd_ev && dec_db_err_i;
    assign w_sb     = w_rd_ev && dec_sb_err_i && !dec_db_err_i;
    assign w_cancel = r_hz || w_hit;

    // A cancelled writeback still counts the corrected error.
    assign w_sb_inc = (w_sb && w_cancel)
                    || ((r_state == WR_REQ) && (w_hit || mem_gnt_i));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (enable_i) w_next = WAIT;
            WAIT: begin
                if (!enable_i)        w_next = IDLE;
                else if (r_cnt == '0) w_next = RD_REQ;
            end
            RD_REQ:  if (mem_gnt_i) w_next = RD_WAIT;
            RD_WAIT: begin
                if (mem_rvalid_i)
                    w_next = (w_sb && !w_cancel) ? WR_REQ : NEXT;
            end
            WR_REQ:  if (w_hit || mem_gnt_i) w_next = NEXT;
            NEXT:    w_next = enable_i ? WAIT : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_hz    <= 1'b0;
            r_irq   <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == WAIT && r_state != WAIT)
                r_cnt <= interval_i;
            else if (r_state == WAIT && r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
            if (r_state == NEXT) r_addr <= r_addr + 1'b1;
            r_pass <= (r_state == NEXT) && (r_addr == '1);
            r_irq  <= w_db;
            r_req  <= (w_next == RD_REQ) || (w_next == WR_REQ);
            r_we   <= (w_next == WR_REQ);
            if (w_sb) r_wdata <= dec_q_i;
            if (r_state == RD_REQ)
                r_hz <= 1'b0;
            else if (r_state == RD_WAIT && w_hit)
                r_hz <= 1'b1;
        end
    end

    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign db_irq_o    = r_irq;
    assign pass_done_o = r_pass;
    assign busy_o      = (r_state != IDLE);

    ecc_err_log #(
        .AW (AW),
        .SW (M + 1)
    ) u_log (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clr_i          (clr_i),
        .sb_inc_i       (w_sb_inc),
        .db_inc_i       (w_db),
        .log_i          (w_sb || w_db),
        .addr_i         (r_addr),
        .syn_i          (dec_syndrome_i),
        .sb_cnt_o       (sb_cnt_o),
        .db_cnt_o       (db_cnt_o),
        .err_addr_o     (err_addr_o),
        .err_syndrome_o (err_syndrome_o),
        .err_valid_o    (err_valid_o)
    );

endmodule
